// File: rtl/hb_pc_pkg.sv
// rtl/hb_pc_pkg.sv - shared address width, phase/op encodings and op priority encoder for pc_unit
package hb_pc_pkg;

    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } phase_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_LD,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // Several requests may be raised together; only the highest-ranked one is applied.
    function automatic pc_op_t pc_prio(input logic inc, input logic ld,
                                       input logic call, input logic ret);
        pc_op_t op;
        if (ret)       op = OP_RET;
        else if (call) op = OP_CALL;
        else if (ld)   op = OP_LD;
        else if (inc)  op = OP_INC;
        else           op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/pc_retstack.sv
// rtl/pc_retstack.sv - DEPTH x ADDR_W LIFO holding call return addresses
module pc_retstack
    import hb_pc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrbar,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_next;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    // sp counts entries, so the next free slot is sp and the top entry is sp-1.
    assign wr_idx  = sp[IDX_W-1:0];
    assign top_idx = wr_idx - IDX_W'(1);
    assign dout    = mem[top_idx];

    always_comb begin
        sp_next = sp;
        if (push && !full)
            sp_next = sp + SP_W'(1);
        else if (pop && !empty)
            sp_next = sp - SP_W'(1);
    end

    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            sp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            sp    <= sp_next;
            empty <= (sp_next == '0);
            full  <= (sp_next == SP_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter and FETCH/EXEC sequencer; return stack built only when PC_RETSTACK_EN is defined
module pc_unit
    import hb_pc_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clrbar,
    input  logic              run,
    input  logic              inc,
    input  logic              ld,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              abarb,
    output logic [1:0]        phase,
    output logic              rco,
    output logic              stk_empty,
    output logic              stk_full,
    output logic              stk_err
);

    phase_t            state;
    phase_t            state_next;
    pc_op_t            op;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              err_set;

    assign pc_inc = pc + ADDR_W'(1);
    // Requests only count on the edge that closes EXEC.
    assign op     = (state == EXEC) ? pc_prio(inc, ld, call, ret) : OP_NONE;
    assign rco    = (op == OP_INC) && (pc == '1);
    assign abarb  = (state == FETCH);
    assign phase  = state;

`ifdef PC_RETSTACK_EN
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] stk_dout;

    pc_retstack #(.DEPTH(DEPTH)) u_retstack (
        .clk    (clk),
        .clrbar (clrbar),
        .push   (push),
        .pop    (pop),
        .din    (pc_inc),
        .dout   (stk_dout),
        .empty  (stk_empty),
        .full   (stk_full)
    );
`else
    localparam int SP_W = $clog2(DEPTH) + 1;
    logic [SP_W-1:0] sp;

    // With no storage the pointer never moves: always empty, never full.
    assign sp        = '0;
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_W'(DEPTH));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = run ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_next = pc;
        err_set = 1'b0;
`ifdef PC_RETSTACK_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (op)
            OP_INC: pc_next = pc_inc;
            OP_LD:  pc_next = target;
`ifdef PC_RETSTACK_EN
            OP_CALL: begin
                pc_next = target;
                if (stk_full) err_set = 1'b1;
                else          push    = 1'b1;
            end
            OP_RET: begin
                if (stk_empty) begin
                    pc_next = pc_inc;
                    err_set = 1'b1;
                end else begin
                    pc_next = stk_dout;
                    pop     = 1'b1;
                end
            end
`else
            OP_CALL: pc_next = target;
            OP_RET: begin
                pc_next = pc_inc;
                err_set = 1'b1;
            end
`endif
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            stk_err <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (err_set)
                stk_err <= 1'b1;
        end
    end

endmodule
